d_bch_enc_sequencer: RTL

- Controls one codeword's pass through the parallel modified-LFS XOR datapath, which sits outside this block.
- Owns the parity register and accepts P_LVL-bit message chunks over a valid/ready stream.
- Each accepted chunk is presented to the datapath, and the returned next parity is registered; the message chunk is also forwarded downstream.
- After the last message chunk, the parity is unloaded MSB-first as P_LVL-bit chunks on the same output stream.

---
 rtl/d_bch_enc_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/d_bch_enc_sequencer.sv
// ---------------------------------------------------------------------------
// d_bch_enc_sequencer
//
// Sequences one BCH codeword through an external, purely combinational
// parallel LFS datapath. This block owns the parity register, accepts
// P_LVL-bit message chunks, forwards each chunk downstream, and after the
// last message chunk unloads the parity MSB-first on the same output stream.
//
// Handshake rule (both streams): a beat transfers on a rising clock edge
// where valid and ready are both 1. A valid beat holds its data stable
// until it transfers. Ready may depend combinationally on the
// consumer-side ready, never on the local valid.
//
// Ports
//   i_clk             clock, rising edge
//   i_RESET           synchronous active-high reset
//   i_start           one-cycle pulse, starts a codeword (IDLE only)
//   i_msg_data        message chunk
//   i_msg_valid       message chunk valid
//   o_msg_ready       message chunk accepted when valid & ready
//   o_lfs_message     datapath message input (= i_msg_data)
//   o_lfs_cur_parity  datapath current parity (= parity register)
//   i_lfs_nxt_parity  datapath next parity (combinational)
//   o_out_data        output chunk (message or parity)
//   o_out_valid       output chunk valid
//   o_out_parity      1 when o_out_data carries parity
//   o_out_last        1 on the final parity chunk of a codeword
//   i_out_ready       downstream ready
//   o_busy            1 whenever state != IDLE
//   o_dbg_state       current FSM state (0 IDLE, 1 MSG, 2 PAR)
// ---------------------------------------------------------------------------
module d_bch_enc_sequencer #(
  parameter int P_LVL      = 8,
  parameter int PRT_LENGTH = 168,
  parameter int MSG_CHUNKS = 256
) (
  input  logic                  i_clk,
  input  logic                  i_RESET,
  input  logic                  i_start,
  input  logic [P_LVL-1:0]      i_msg_data,
  input  logic                  i_msg_valid,
  output logic                  o_msg_ready,
  output logic [P_LVL-1:0]      o_lfs_message,
  output logic [PRT_LENGTH-1:0] o_lfs_cur_parity,
  input  logic [PRT_LENGTH-1:0] i_lfs_nxt_parity,
  output logic [P_LVL-1:0]      o_out_data,
  output logic                  o_out_valid,
  output logic                  o_out_parity,
  output logic                  o_out_last,
  input  logic                  i_out_ready,
  output logic                  o_busy,
  output logic [1:0]            o_dbg_state
);

  localparam int PAR_CHUNKS = PRT_LENGTH / P_LVL;
  localparam int CNT_MAX    = (MSG_CHUNKS > PAR_CHUNKS) ? MSG_CHUNKS : PAR_CHUNKS;
  localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MSG  = 2'd1,
    S_PAR  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [PRT_LENGTH-1:0] par_q, par_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [P_LVL-1:0]      out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_parity_q, out_parity_d;
  logic                  out_last_q, out_last_d;

  logic out_free;
  logic msg_accept;
  logic par_load;
  logic msg_last;
  logic par_last;

  // The output register is single-entry: it may be (re)loaded when empty or
  // when its current beat transfers on this same edge.
  assign out_free   = !out_valid_q || i_out_ready;
  assign msg_accept = (state_q == S_MSG) && out_free && i_msg_valid;
  assign par_load   = (state_q == S_PAR) && out_free;
  assign msg_last   = (cnt_q == CNT_W'(MSG_CHUNKS - 1));
  assign par_last   = (cnt_q == CNT_W'(PAR_CHUNKS - 1));

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_RESET) begin
      state_q      <= S_IDLE;
      par_q        <= '0;
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_parity_q <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      par_q        <= par_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_parity_q <= out_parity_d;
      out_last_q   <= out_last_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (i_start) state_d = S_MSG;
      S_MSG:   if (msg_accept && msg_last) state_d = S_PAR;
      S_PAR:   if (par_load && par_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    par_d        = par_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    // A consumed beat empties the register unless a load below refills it.
    out_valid_d  = out_valid_q && !i_out_ready;
    out_parity_d = out_parity_q;
    out_last_d   = out_last_q;
    o_msg_ready  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          par_d = '0;
          cnt_d = '0;
        end
      end
      S_MSG: begin
        o_msg_ready = out_free;
        if (msg_accept) begin
          par_d        = i_lfs_nxt_parity;
          out_data_d   = i_msg_data;
          out_valid_d  = 1'b1;
          out_parity_d = 1'b0;
          out_last_d   = 1'b0;
          cnt_d        = msg_last ? '0 : cnt_q + CNT_W'(1);
        end
      end
      S_PAR: begin
        if (par_load) begin
          out_data_d   = par_q[PRT_LENGTH-1 -: P_LVL];
          par_d        = par_q << P_LVL;
          out_valid_d  = 1'b1;
          out_parity_d = 1'b1;
          out_last_d   = par_last;
          cnt_d        = par_last ? '0 : cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign o_lfs_message    = i_msg_data;
  assign o_lfs_cur_parity = par_q;
  assign o_out_data       = out_data_q;
  assign o_out_valid      = out_valid_q;
  assign o_out_parity     = out_parity_q;
  assign o_out_last       = out_last_q;
  assign o_busy           = (state_q != S_IDLE);
  assign o_dbg_state      = state_q;

endmodule
